button_onehot_capture: RTL and testbench
========================================

BUTTON_ONEHOT_CAPTURE -- requirements
Module: button_onehot_capture

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable synchronized samples required to change a debounced level; legal range 2..1023.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btn_raw  input  4  asynchronous active-high button levels; bit i = button i.
REQ-005 out_ready  input  1  downstream (4x2 encoder consumer) accepts current code.
REQ-006 out_valid  output  1  onehot_out holds one captured press.
REQ-007 onehot_out  output  4  exactly one bit set while out_valid=1; 4'b0000 otherwise.
REQ-008 btn_level  output  4  debounced button levels, for status/LEDs.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Per bit: counter cleared whenever the synchronized sample equals btn_level[i]; otherwise increments; when it reaches DEB_CYCLES, btn_level[i] toggles and the counter clears on the same edge.
REQ-011 Counter width SHALL be clog2(DEB_CYCLES+1); counter SHALL never wrap.
REQ-012 Press event[i] = btn_level[i] rising (0 to 1) on a clock edge.
REQ-013 FSM states: IDLE, PRESENT, WAIT_REL.
REQ-014 IDLE: on any press event, capture the lowest-index pressed bit as one-hot into onehot_out, assert out_valid on the next edge, go to PRESENT.
REQ-015 Simultaneous press events: lowest index wins; other events discarded.
REQ-016 Latency: btn_raw[i] stable high from edge 0 -> out_valid=1 after exactly DEB_CYCLES+3 edges.
REQ-017 PRESENT: out_valid and onehot_out SHALL hold constant until out_valid && out_ready is sampled on an edge.
REQ-018 On handshake: the next edge clears out_valid, sets onehot_out=0, and moves to WAIT_REL.
REQ-019 out_ready high while out_valid low SHALL have no effect.
REQ-020 WAIT_REL: stay until btn_level==4'b0000, then IDLE on the next edge.
REQ-021 Press events in PRESENT or WAIT_REL SHALL be dropped, not queued.
REQ-022 A glitch shorter than DEB_CYCLES synchronized cycles SHALL NOT change btn_level or create an event.

Reset
REQ-023 rst=1 SHALL immediately clear: synchronizers, counters, btn_level=0, state=IDLE, out_valid=0, onehot_out=0.
REQ-024 Reset mid-handshake SHALL discard the pending code; no output after release until a new debounced press.
REQ-025 A button held through reset SHALL register as a press DEB_CYCLES+3 edges after rst deasserts.

Structure
REQ-026 Shared package: FSM state encoding (2-bit localparams IDLE=0, PRESENT=1, WAIT_REL=2), default DEB_CYCLES, button count 4.
REQ-027 One sub-module, debounce_cell (synchronizer + counter + level + rise pulse), instantiated 4 times; top holds priority pick and FSM.
REQ-028 No latches; unused state 3 SHALL recover to IDLE on the next edge.

Verification (DEB_CYCLES=4)
REQ-029 Hold btn_raw=4'b0100 from edge 0, out_ready=0 -> out_valid=1, onehot_out=4'b0100 at edge 7, held indefinitely.
REQ-030 With REQ-029 state, pulse out_ready 1 cycle -> next edge out_valid=0, onehot_out=0; release btn -> IDLE after 7 edges.
REQ-031 btn_raw=4'b1010 rising on the same edge -> onehot_out=4'b0010 only; bit 3 dropped.
REQ-032 btn_raw[0] glitch high for 3 cycles -> btn_level stays 0, out_valid stays 0.
REQ-033 Press in WAIT_REL (button 1 held, press button 2) -> no new out_valid until all released and a fresh press.
REQ-034 Assert rst while out_valid=1 with button held -> outputs 0 at once; after release of rst, out_valid=1 again at edge 7.

Source files
------------

// File: rtl/button_onehot_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_onehot_capture_pkg
// Description : Shared constants for the button one-hot capture block:
//               FSM state encoding, default debounce length, button count
//               and a lowest-set-bit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package button_onehot_capture_pkg;

  localparam int NUM_BTNS           = 4;
  localparam int DEB_CYCLES_DEFAULT = 16;

  // Capture FSM encoding; code 3 is unused and recovers to IDLE.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESENT  = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  // Isolates the lowest set bit (two's-complement trick), giving the
  // lowest-index-wins priority pick as a one-hot vector.
  function automatic logic [NUM_BTNS-1:0] lowest_onehot(input logic [NUM_BTNS-1:0] v);
    return v & (~v + NUM_BTNS'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_onehot_capture_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : One button lane: 2-flop synchronizer, stability counter,
//               debounced level and a registered one-cycle rise pulse.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               i_btn_raw  - asynchronous raw button level
//               o_level    - debounced level
//               o_rise     - one-cycle pulse, one edge after o_level rises
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_cell
  import button_onehot_capture_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int              c_cnt_w    = $clog2(DEB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_d;
  logic               r_rise;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        // This edge supplies the DEB_CYCLES-th differing sample: flip the
        // level and restart, so the counter never reaches DEB_CYCLES or wraps.
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/button_onehot_capture.sv
`default_nettype none
// ============================================================================
// Module      : button_onehot_capture
// Description : Debounces four buttons and presents the lowest-index new
//               press as a one-hot code with a valid/ready handshake. A code
//               is produced only when all buttons have been released since
//               the previous one was accepted.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               btn_raw    - raw asynchronous button levels
//               out_ready  - consumer accepts the current code
//               out_valid  - onehot_out holds a captured press
//               onehot_out - captured one-hot code, zero when not valid
//               btn_level  - debounced button levels
// Revision    : 1.0 - initial release
// ============================================================================
module button_onehot_capture
  import button_onehot_capture_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [NUM_BTNS-1:0] onehot_out,
  output logic [NUM_BTNS-1:0] btn_level
);

  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_rise;
  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [NUM_BTNS-1:0] r_code;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    debounce_cell #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_btn_raw (btn_raw[g]),
      .o_level   (w_level[g]),
      .o_rise    (w_rise[g])
    );
  end

  assign btn_level = w_level;

  // State register plus the captured code, which only loads on IDLE->PRESENT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && (|w_rise)) begin
        r_code <= lowest_onehot(w_rise);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (|w_rise)           w_next_state = PRESENT;
      // out_valid is high throughout PRESENT, so out_ready alone completes
      // the handshake here.
      PRESENT:  if (out_ready)         w_next_state = WAIT_REL;
      WAIT_REL: if (w_level == '0)     w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = 1'b0;
    onehot_out = '0;
    if (r_state == PRESENT) begin
      out_valid  = 1'b1;
      onehot_out = r_code;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_onehot_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_onehot_capture
// Description : Self-checking bench for button_onehot_capture (DEB_CYCLES=4).
//               A history-based reference model predicts levels and codes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_onehot_capture;

  localparam int DEB    = 4;
  localparam int M_IDLE = 0;
  localparam int M_PRES = 1;
  localparam int M_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] onehot_out;
  logic [3:0] btn_level;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw input seen at each edge since reset, level-rise
  // history, and the consumer-visible mode.
  logic [3:0] m_raw[$];
  logic [3:0] m_rise[$];
  logic [3:0] m_lvl;
  logic [3:0] m_code;
  int         m_mode;
  logic       m_valid;
  logic [3:0] m_onehot;

  always #5 clk = ~clk;

  button_onehot_capture #(
    .DEB_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .onehot_out (onehot_out),
    .btn_level  (btn_level)
  );

  function automatic logic [3:0] first_set(input logic [3:0] v);
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < 4; i++) if (v[i]) return one << i;
    return 4'b0000;
  endfunction

  // Synchronized sample used at edge j: the raw value captured two edges earlier.
  function automatic logic [3:0] sync_at(input int j);
    return (j >= 2) ? m_raw[j-2] : 4'b0000;
  endfunction

  task automatic model_reset();
    m_raw.delete();
    m_rise.delete();
    m_lvl    = 4'b0;
    m_code   = 4'b0;
    m_mode   = M_IDLE;
    m_valid  = 1'b0;
    m_onehot = 4'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic ready);
    int         k;
    logic [3:0] old_lvl;
    logic [3:0] seen;
    logic [3:0] s;
    bit         flip;
    k = m_raw.size();
    m_raw.push_back(raw);
    old_lvl = m_lvl;
    // A level flips once the last DEB synchronized samples all disagree with it.
    for (int i = 0; i < 4; i++) begin
      flip = (k - DEB + 1 >= 0);
      for (int j = k - DEB + 1; j <= k; j++) begin
        if (j >= 0) begin
          s = sync_at(j);
          if (s[i] == old_lvl[i]) flip = 0;
        end
      end
      if (flip) m_lvl[i] = ~old_lvl[i];
    end
    m_rise.push_back(m_lvl & ~old_lvl);
    // A level rise becomes a captured code two edges later.
    seen = (k >= 2) ? m_rise[k-2] : 4'b0000;
    case (m_mode)
      M_IDLE: if (seen != 4'b0) begin m_code = first_set(seen); m_mode = M_PRES; end
      M_PRES: if (ready) m_mode = M_WAIT;
      default: if (old_lvl == 4'b0) m_mode = M_IDLE;
    endcase
    m_valid  = (m_mode == M_PRES);
    m_onehot = m_valid ? m_code : 4'b0;
  endtask

  task automatic step(input logic [3:0] raw, input logic ready);
    btn_raw   = raw;
    out_ready = ready;
    @(posedge clk);
    #1;
    model_edge(raw, ready);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_raw = 4'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || onehot_out !== 4'b0 || btn_level !== 4'b0) begin
      failures++;
      $display("FAIL reset_async valid=%b onehot=%b level=%b expected 0/0000/0000", out_valid, onehot_out, btn_level);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    for (int e = 0; e < 18; e++) begin
      step(4'b0100, 1'b0);
      checks++;
      if (out_valid !== m_valid || onehot_out !== m_onehot || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL latency_model e=%0d valid=%b/%b onehot=%b/%b level=%b/%b", e, out_valid, m_valid, onehot_out, m_onehot, btn_level, m_lvl);
      end
      if (e == 6 || e == 7 || e == 17) begin
        checks++;
        if (out_valid !== (e != 6) || onehot_out !== ((e != 6) ? 4'b0100 : 4'b0000)) begin
          failures++;
          $display("FAIL latency_edge e=%0d valid=%b onehot=%b", e, out_valid, onehot_out);
        end
      end
    end
  endtask

  task automatic test_handshake();
    step(4'b0100, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || onehot_out !== 4'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL handshake_clear valid=%b onehot=%b expected 0/0000", out_valid, onehot_out);
    end
    // Release, then a fresh press on button 0 must come out with full latency.
    for (int e = 0; e < 7; e++) step(4'b0000, 1'b1);
    for (int e = 0; e < 10; e++) begin
      step(4'b0001, 1'b0);
      checks++;
      if (out_valid !== m_valid || onehot_out !== m_onehot || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL rearm_model e=%0d valid=%b/%b onehot=%b/%b level=%b/%b", e, out_valid, m_valid, onehot_out, m_onehot, btn_level, m_lvl);
      end
      if (e == 7) begin
        checks++;
        if (out_valid !== 1'b1 || onehot_out !== 4'b0001) begin
          failures++;
          $display("FAIL rearm_edge valid=%b onehot=%b expected 1/0001", out_valid, onehot_out);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int e = 0; e < 12; e++) begin
      step(4'b1010, 1'b0);
      checks++;
      if (out_valid !== m_valid || onehot_out !== m_onehot || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL simul_model e=%0d valid=%b/%b onehot=%b/%b level=%b/%b", e, out_valid, m_valid, onehot_out, m_onehot, btn_level, m_lvl);
      end
    end
    checks++;
    if (onehot_out !== 4'b0010 || btn_level !== 4'b1010) begin
      failures++;
      $display("FAIL simul_priority onehot=%b level=%b expected 0010/1010", onehot_out, btn_level);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int e = 0; e < 14; e++) begin
      step((e < 3) ? 4'b0001 : 4'b0000, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || btn_level !== 4'b0 || m_lvl !== 4'b0) begin
        failures++;
        $display("FAIL glitch e=%0d valid=%b level=%b expected 0/0000", e, out_valid, btn_level);
      end
    end
  endtask

  task automatic test_wait_rel();
    int seen_valid;
    apply_reset();
    for (int e = 0; e < 8; e++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    seen_valid = 0;
    for (int e = 0; e < 12; e++) begin
      step(4'b0110, 1'b0);
      if (out_valid !== 1'b0) seen_valid++;
    end
    checks++;
    if (seen_valid != 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_rel_drop valid_cycles=%0d expected 0", seen_valid);
    end
    for (int e = 0; e < 8; e++) step(4'b0000, 1'b0);
    for (int e = 0; e < 8; e++) begin
      step(4'b0100, 1'b0);
      checks++;
      if (out_valid !== m_valid || onehot_out !== m_onehot || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL wait_rel_fresh e=%0d valid=%b/%b onehot=%b/%b level=%b/%b", e, out_valid, m_valid, onehot_out, m_onehot, btn_level, m_lvl);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || onehot_out !== 4'b0100) begin
      failures++;
      $display("FAIL wait_rel_newpress valid=%b onehot=%b expected 1/0100", out_valid, onehot_out);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int e = 0; e < 9; e++) step(4'b0100, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || onehot_out !== 4'b0 || btn_level !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_clear valid=%b onehot=%b level=%b expected 0/0000/0000", out_valid, onehot_out, btn_level);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step(4'b0100, 1'b0);
      checks++;
      if (out_valid !== m_valid || onehot_out !== m_onehot || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL reset_mid_model e=%0d valid=%b/%b onehot=%b/%b level=%b/%b", e, out_valid, m_valid, onehot_out, m_onehot, btn_level, m_lvl);
      end
      if (e == 6 || e == 7) begin
        checks++;
        if (out_valid !== (e == 7)) begin
          failures++;
          $display("FAIL reset_mid_latency e=%0d valid=%b", e, out_valid);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] raw;
    int         hold;
    apply_reset();
    raw  = 4'b0;
    hold = 0;
    for (int e = 0; e < 600; e++) begin
      if (hold == 0) begin
        raw  = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 9);
      end
      hold--;
      step(raw, ($urandom_range(0, 3) == 0));
      checks++;
      if (out_valid !== m_valid || onehot_out !== m_onehot || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL random e=%0d raw=%b valid=%b/%b onehot=%b/%b level=%b/%b", e, raw, out_valid, m_valid, onehot_out, m_onehot, btn_level, m_lvl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_handshake();
    test_simultaneous();
    test_glitch();
    test_wait_rel();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
